// File: rtl/zeroriscy_vector_regfile_pipe.sv
// Vector register file: two combinational read ports, one pipelined masked/broadcast write port,
// and a one-register-per-cycle clear sweep. Optional write-stage forwarding: ZERORISCY_VRF_BYPASS_EN.
module zeroriscy_vector_regfile_pipe #(
    parameter  int NUM_REGS   = 16,
    parameter  int NUM_LANES  = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = $clog2(NUM_REGS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [AW-1:0]                         raddr_a_i,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  rdata_a_o,
    input  logic [AW-1:0]                         raddr_b_i,
    output logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  rdata_b_o,
    input  logic                                  we_i,
    output logic                                  wr_ready_o,
    input  logic [AW-1:0]                         waddr_i,
    input  logic [NUM_LANES-1:0][DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_LANES-1:0]                  wmask_i,
    input  logic                                  wbcast_i,
    input  logic                                  clr_req_i,
    output logic                                  clr_busy_o
);

    typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vreg_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGS - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [AW-1:0]          r_clr_cnt;
    logic [AW-1:0]          w_clr_cnt_nxt;

    logic                   r_wr_valid;
    logic [AW-1:0]          r_wr_addr;
    logic [NUM_LANES-1:0]   r_wr_mask;
    vreg_t                  r_wr_data;

    vreg_t                  r_mem [NUM_REGS];

    logic                   w_wr_accept;
    vreg_t                  w_wdata_eff;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves an output unassigned (no latch).
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        wr_ready_o    = 1'b0;
        clr_busy_o    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                wr_ready_o = 1'b1;
                if (clr_req_i) begin
                    w_state_nxt   = ST_SWEEP;
                    w_clr_cnt_nxt = '0;
                end
            end
            ST_SWEEP: begin
                clr_busy_o = 1'b1;
                // Further clear requests are ignored here; the sweep never restarts.
                if (r_clr_cnt == LAST_REG) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write stage: broadcast is resolved before the data is registered
    // ------------------------------------------------------------------
    assign w_wr_accept = we_i && wr_ready_o;

    always_comb begin
        w_wdata_eff = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            w_wdata_eff[l] = wbcast_i ? wdata_i[0] : wdata_i[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_mask  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= w_wr_accept;
            if (w_wr_accept) begin
                r_wr_addr <= waddr_i;
                r_wr_mask <= wmask_i;
                r_wr_data <= w_wdata_eff;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: commit then clear, so the sweep wins a same-edge collision
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset explicitly; a reset mid-sweep must still leave every register zero.
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            if (r_wr_valid) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (r_wr_mask[l]) begin
                        r_mem[r_wr_addr][l] <= r_wr_data[l];
                    end
                end
            end
            if (r_state == ST_SWEEP) begin
                r_mem[r_clr_cnt] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        rdata_a_o = r_mem[raddr_a_i];
        rdata_b_o = r_mem[raddr_b_i];
`ifdef ZERORISCY_VRF_BYPASS_EN
        // Forward only the lanes the pending write will actually change.
        for (int l = 0; l < NUM_LANES; l++) begin
            if (r_wr_valid && (r_wr_addr == raddr_a_i) && r_wr_mask[l]) begin
                rdata_a_o[l] = r_wr_data[l];
            end
            if (r_wr_valid && (r_wr_addr == raddr_b_i) && r_wr_mask[l]) begin
                rdata_b_o[l] = r_wr_data[l];
            end
        end
`else
        // Array contents only: new data appears two cycles after acceptance.
`endif
    end

endmodule

// File: tb/tb_zeroriscy_vector_regfile_pipe.sv
// Scoreboard bench for zeroriscy_vector_regfile_pipe: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them. Honours ZERORISCY_VRF_BYPASS_EN for forwarding timing.
module tb_zeroriscy_vector_regfile_pipe;

    localparam int NUM_REGS   = 16;
    localparam int NUM_LANES  = 4;
    localparam int DATA_WIDTH = 32;
    localparam int AW         = 4;

    typedef logic [NUM_LANES-1:0][DATA_WIDTH-1:0] vreg_t;
    typedef enum int {K_RDA, K_RDB, K_READY, K_BUSY} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        vreg_t exp;
        string name;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [AW-1:0]        raddr_a_i = '0;
    vreg_t                rdata_a_o;
    logic [AW-1:0]        raddr_b_i = '0;
    vreg_t                rdata_b_o;
    logic                 we_i = 1'b0;
    logic                 wr_ready_o;
    logic [AW-1:0]        waddr_i = '0;
    vreg_t                wdata_i = '0;
    logic [NUM_LANES-1:0] wmask_i = '0;
    logic                 wbcast_i = 1'b0;
    logic                 clr_req_i = 1'b0;
    logic                 clr_busy_o;

    zeroriscy_vector_regfile_pipe #(
        .NUM_REGS   (NUM_REGS),
        .NUM_LANES  (NUM_LANES),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raddr_a_i  (raddr_a_i),
        .rdata_a_o  (rdata_a_o),
        .raddr_b_i  (raddr_b_i),
        .rdata_b_o  (rdata_b_o),
        .we_i       (we_i),
        .wr_ready_o (wr_ready_o),
        .waddr_i    (waddr_i),
        .wdata_i    (wdata_i),
        .wmask_i    (wmask_i),
        .wbcast_i   (wbcast_i),
        .clr_req_i  (clr_req_i),
        .clr_busy_o (clr_busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vreg_t lanes4(logic [31:0] l3, logic [31:0] l2, logic [31:0] l1, logic [31:0] l0);
        vreg_t v;
        v[3] = l3;
        v[2] = l2;
        v[1] = l1;
        v[0] = l0;
        return v;
    endfunction

    function automatic vreg_t fill(int r);
        vreg_t v;
        for (int l = 0; l < NUM_LANES; l++) begin
            v[l] = 32'h1000_0000 | 32'(r << 8) | 32'(l + 1);
        end
        return v;
    endfunction

    function automatic vreg_t bitv(logic b);
        vreg_t v;
        v       = '0;
        v[0][0] = b;
        return v;
    endfunction

    task automatic check(string name, vreg_t act, vreg_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin : monitor
        exp_t  e;
        vreg_t act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_RDA:   act = rdata_a_o;
                K_RDB:   act = rdata_b_o;
                K_READY: act = bitv(wr_ready_o);
                default: act = bitv(clr_busy_o);
            endcase
            check(e.name, act, e.exp);
        end
    end

    task automatic push_exp(kind_e k, vreg_t v, string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(int a, int b, vreg_t ea, vreg_t eb, string name);
        raddr_a_i = AW'(a);
        raddr_b_i = AW'(b);
        push_exp(K_RDA, ea, {name, "_a"});
        push_exp(K_RDB, eb, {name, "_b"});
    endtask

    task automatic status(logic ready, logic busy, string name);
        push_exp(K_READY, bitv(ready), {name, "_ready"});
        push_exp(K_BUSY, bitv(busy), {name, "_busy"});
    endtask

    task automatic write(int addr, vreg_t data, logic [NUM_LANES-1:0] mask, logic bcast);
        we_i     = 1'b1;
        waddr_i  = AW'(addr);
        wdata_i  = data;
        wmask_i  = mask;
        wbcast_i = bcast;
    endtask

    task automatic no_write();
        we_i     = 1'b0;
        wbcast_i = 1'b0;
        wmask_i  = '0;
    endtask

    task automatic fill_all();
        for (int r = 0; r < NUM_REGS; r++) begin
            write(r, fill(r), 4'hF, 1'b0);
            tick();
        end
        no_write();
        tick();
    endtask

    task automatic read_all_zero(string name);
        for (int r = 0; r < NUM_REGS / 2; r++) begin
            rd(r, r + NUM_REGS / 2, '0, '0, name);
            tick();
        end
    endtask

    vreg_t v3;
    vreg_t v_new3;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            rd(r, NUM_REGS - 1 - r, '0, '0, "reset_rd");
            status(1'b1, 1'b0, "reset");
            tick();
        end

        // ---------------- write latency / bypass ----------------
        v3 = lanes4(32'h44, 32'h33, 32'h22, 32'h11);
        write(3, v3, 4'hF, 1'b0);
        rd(3, 3, '0, '0, "wr3_cycN");
        tick();
        no_write();
`ifdef ZERORISCY_VRF_BYPASS_EN
        rd(3, 3, v3, v3, "wr3_cycN1");
`else
        rd(3, 3, '0, '0, "wr3_cycN1");
`endif
        tick();
        rd(3, 3, v3, v3, "wr3_cycN2");
        tick();

        // All-zero mask is accepted but changes nothing.
        write(3, {NUM_LANES{32'hFFFF_FFFF}}, 4'h0, 1'b0);
        tick();
        no_write();
        rd(3, 3, v3, v3, "mask0_n1");
        tick();
        rd(3, 3, v3, v3, "mask0_n2");
        tick();

        // Partial mask without broadcast.
        write(3, lanes4(32'hAA, 32'hBB, 32'hCC, 32'hDD), 4'b0110, 1'b0);
        tick();
        no_write();
        tick();
        v_new3 = lanes4(32'h44, 32'hBB, 32'hCC, 32'h11);
        rd(3, 3, v_new3, v_new3, "partial_mask");
        tick();

        // ---------------- broadcast with mask ----------------
        write(5, lanes4(32'hA, 32'hA, 32'hA, 32'hA), 4'hF, 1'b0);
        tick();
        write(5, lanes4(32'h55, 32'h66, 32'h77, 32'hDEADBEEF), 4'b0101, 1'b1);
        tick();
        no_write();
        tick();
        rd(5, 5, lanes4(32'hA, 32'hDEADBEEF, 32'hA, 32'hDEADBEEF),
                 lanes4(32'hA, 32'hDEADBEEF, 32'hA, 32'hDEADBEEF), "bcast5");
        tick();

        // ---------------- back-to-back writes to one register ----------------
        write(7, lanes4(1, 2, 3, 4), 4'hF, 1'b0);
        tick();
        write(7, lanes4(5, 6, 7, 8), 4'hF, 1'b0);
        tick();
        no_write();
        tick();
        rd(7, 3, lanes4(5, 6, 7, 8), v_new3, "b2b_last_wins");
        tick();

        // ---------------- fill all, then full sweep with writes held ----------------
        fill_all();
        for (int r = 0; r < NUM_REGS; r++) begin
            rd(r, NUM_REGS - 1 - r, fill(r), fill(NUM_REGS - 1 - r), "fill_rd");
            tick();
        end
        clr_req_i = 1'b1;
        status(1'b1, 1'b0, "sweep_req");
        tick();
        for (int i = 1; i <= NUM_REGS; i++) begin
            clr_req_i = 1'b1;
            write(2, {NUM_LANES{32'hFFFF_FFFF}}, 4'hF, 1'b0);
            status(1'b0, 1'b1, $sformatf("sweep%0d", i));
            if (i >= 2) begin
                rd(i - 2, i - 1, '0, fill(i - 1), $sformatf("sweep%0d_rd", i));
            end else begin
                rd(0, 0, fill(0), fill(0), "sweep1_rd");
            end
            tick();
        end
        clr_req_i = 1'b0;
        no_write();
        status(1'b1, 1'b0, "sweep_done");
        tick();
        read_all_zero("after_sweep");

        // ---------------- reset aborts a sweep ----------------
        fill_all();
        clr_req_i = 1'b1;
        tick();
        clr_req_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            status(1'b0, 1'b1, $sformatf("abort_sweep%0d", i));
            tick();
        end
        rst = 1'b1;
        status(1'b0, 1'b1, "abort_sweep5");
        tick();
        rst = 1'b0;
        status(1'b1, 1'b0, "abort_after");
        tick();
        status(1'b1, 1'b0, "abort_after2");
        read_all_zero("after_abort");

        // ---------------- write and clear in the same idle cycle ----------------
        write(0, {NUM_LANES{32'h1234}}, 4'hF, 1'b0);
        clr_req_i = 1'b1;
        status(1'b1, 1'b0, "wrclr_n");
        tick();
        no_write();
        clr_req_i = 1'b0;
        status(1'b0, 1'b1, "wrclr_n1");
`ifdef ZERORISCY_VRF_BYPASS_EN
        rd(0, 0, {NUM_LANES{32'h1234}}, {NUM_LANES{32'h1234}}, "wrclr_n1");
`else
        rd(0, 0, '0, '0, "wrclr_n1");
`endif
        tick();
        rd(0, 0, '0, '0, "wrclr_n2");
        tick();
        for (int i = 3; i <= NUM_REGS; i++) begin
            tick();
        end
        status(1'b1, 1'b0, "wrclr_done");
        rd(0, 1, '0, '0, "wrclr_final");
        tick();

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zeroriscy_vector_regfile_pipe.md
# zeroriscy_vector_regfile_pipe

Parametrised vector register file for the zeroriscy vector extension: `NUM_REGS` registers of `NUM_LANES` x `DATA_WIDTH` lanes, two combinational read ports and one pipelined write port. Writes support per-lane masking and lane-0 broadcast. An optional write-stage bypass forwards pending writes to the read ports. A clear sequencer zeroes the whole file one register per cycle. The block sits between vector decode (read ports) and vector writeback (write port).

## Interface
- `NUM_REGS`, 16, number of vector registers; `AW = $clog2(NUM_REGS)`
- `NUM_LANES`, 4, lanes per register
- `DATA_WIDTH`, 32, bits per lane
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `raddr_a_i`  in  AW  read port A address
- `rdata_a_o`  out  NUM_LANES x DATA_WIDTH  read port A data
- `raddr_b_i`  in  AW  read port B address
- `rdata_b_o`  out  NUM_LANES x DATA_WIDTH  read port B data
- `we_i`  in  1  write request
- `wr_ready_o`  out  1  write port can accept
- `waddr_i`  in  AW  write address
- `wdata_i`  in  NUM_LANES x DATA_WIDTH  write data
- `wmask_i`  in  NUM_LANES  per-lane write enable
- `wbcast_i`  in  1  1 = replicate lane 0 of `wdata_i` to all lanes before masking
- `clr_req_i`  in  1  start a clear sweep
- `clr_busy_o`  out  1  sweep in progress

## Operation
- Storage: array `NUM_REGS` x `NUM_LANES` x `DATA_WIDTH`.
- Write handshake: a write is accepted on a cycle with `we_i && wr_ready_o`.
  - An accepted write loads the write stage: valid, addr, mask, effective data (broadcast already applied).
  - `we_i` while `wr_ready_o = 0` is dropped. There is no backpressure memory.
- Commit: a valid write stage updates only the masked lanes of `array[addr]` on the next edge, then clears valid unless a new write is accepted on that edge.
  - An all-zero mask is accepted, commits, and changes nothing.
- Reads are combinational from the array. Ports A and B are independent, and the same address on both ports is legal.
- Clear FSM, states IDLE and SWEEP, with counter `clr_cnt` of width AW:
  - IDLE: `wr_ready_o = 1`, `clr_busy_o = 0`. `clr_req_i = 1` → SWEEP with `clr_cnt = 0`.
  - SWEEP: `wr_ready_o = 0`, `clr_busy_o = 1`. Each cycle zeroes all lanes of `array[clr_cnt]` and increments the counter. After zeroing register `NUM_REGS-1` → IDLE.
  - `clr_req_i` during SWEEP is ignored. There is no restart.
- Simultaneous `we_i` and `clr_req_i` in IDLE: the write is accepted, commits on the SWEEP entry edge, and is then wiped by the sweep. The end state is all zeros.
- Reset: array all zero, write stage invalid, state IDLE, `clr_cnt = 0`.
  - Reset mid-sweep aborts the sweep to IDLE. The array still ends up zero.

## Timing
- Reset values of outputs: `rdata_a_o = rdata_b_o = 0` (array zero), `wr_ready_o = 1`, `clr_busy_o = 0`.
- Write accepted in cycle N: array holds the new value from cycle N+2.
  - With bypass, reads show the new value from cycle N+1.
  - A read in cycle N always returns the old value.
- Back-to-back writes, one per cycle, are sustained. Consecutive writes to the same register commit in order, last one wins.
- Clear: `clr_req_i` sampled high at the end of cycle N gives `clr_busy_o = 1` for cycles N+1 … N+NUM_REGS.
  - `wr_ready_o` returns to 1 in cycle N+NUM_REGS+1.
  - `array[k]` reads zero from cycle N+k+2.

## Configuration
- `ZERORISCY_VRF_BYPASS_EN` defined:
  - Each read port compares its address with a valid write stage.
  - On a match, masked lanes return write-stage data; unmasked lanes return array data.
  - Ports A and B are forwarded independently.
- Macro undefined: no forwarding logic. Reads return array contents only, so new data is visible 2 cycles after acceptance.

## Test plan
- Reset then read all registers on both ports → every lane 0; `wr_ready_o = 1`; `clr_busy_o = 0`.
- Write reg 3 with lanes `{0x44,0x33,0x22,0x11}`, mask `4'b1111`, in cycle N. Read reg 3 on port A in N+1 and N+2:
  - bypass on → `{0x44,0x33,0x22,0x11}` both cycles;
  - bypass off → 0 in N+1, new value in N+2.
- Write reg 5 = `0xDEADBEEF` broadcast with mask `4'b0101`, lanes previously `0xA` → lanes `{0xA,0xDEADBEEF,0xA,0xDEADBEEF}`, read on both ports.
- Fill all 16 registers non-zero, pulse `clr_req_i` and hold `we_i` during the sweep:
  - `clr_busy_o` high exactly 16 cycles and writes are dropped;
  - all registers read 0 afterwards;
  - `wr_ready_o` is 1 again the following cycle.
- Assert `rst` at sweep cycle 5 → `clr_busy_o = 0` and `wr_ready_o = 1` next cycle; all registers read 0.
- `we_i` and `clr_req_i` in the same IDLE cycle, writing reg 0 = `0x1234` → reg 0 reads 0 after the sweep completes.
